clausedb_scan: RTL
==================

# clausedb_scan

Parametrised clause-database memory for the hardware BCP engine. It is the successor to the plain `clausedb` RAM and keeps the same single-port host access: `en`/`r_w`/`address`/`din`/`dout`. It adds three things:
- a per-entry valid bit, with an entry count and a delete operation;
- a registered read with a hit flag;
- an autonomous scan engine that streams every valid clause to the BCP datapath over a valid/ready handshake.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: clause word width in bits.
- `ADDR_WIDTH`, default 8: host and scan address width.
- `DEPTH`, default 256: number of entries, with 1 ≤ DEPTH ≤ 2^ADDR_WIDTH.

Ports:
- `clock` in, 1: single clock, rising edge.
- `reset` in, 1: asynchronous, active-high.
- `en` in, 1: host operation request.
- `r_w` in, 1: 1 = read, 0 = write.
- `del` in, 1: with `en`, invalidate entry (priority over `r_w`).
- `address` in, ADDR_WIDTH: host entry address.
- `din` in, DATA_WIDTH: write data.
- `dout` out, DATA_WIDTH: registered read data.
- `dout_valid` out, 1: one-cycle pulse, read result present.
- `dout_hit` out, 1: addressed entry was valid (qualified by `dout_valid`).
- `err` out, 1: one-cycle pulse, host `address` ≥ DEPTH.
- `count` out, ADDR_WIDTH+1: number of valid entries.
- `scan_start` in, 1: start a scan; honoured in IDLE only.
- `scan_ready` in, 1: consumer accepts the presented clause.
- `scan_valid` out, 1: clause presented.
- `scan_data` out, DATA_WIDTH: presented clause.
- `scan_addr` out, ADDR_WIDTH: address of the presented clause.
- `busy` out, 1: scan engine not in IDLE.
- `scan_done` out, 1: one-cycle pulse at end of a scan.

## Operation
Host operations (one per cycle, sampled on the rising edge when `en`=1):
- `del`=1: clear `valid[address]`. `count` decrements only if the entry was valid. Data is untouched. No `dout_valid`.
- `del`=0, `r_w`=0: `mem[address]`←`din`, set valid. `count` increments only if the entry was previously invalid.
- `del`=0, `r_w`=1: next cycle `dout`=`mem[address]`, `dout_hit`=`valid[address]`, `dout_valid`=1. Data is returned even when the entry is invalid. `dout` holds its value until the next read.
- Any operation with `address` ≥ DEPTH: no state change, `err`=1 the next cycle, no `dout_valid`.

`count` arithmetic is unsigned and exact. It saturates naturally at DEPTH because an overwrite does not increment.

Scan FSM:
- **IDLE:** if `scan_start`, then `ptr`←0 and go to FETCH. `busy`=0.
- **FETCH:**
  - If `ptr`==DEPTH, go to DONE.
  - Else, if a host `en` is active this cycle, stall: no `ptr` change.
  - Else, if `valid[ptr]`, register `scan_data`←`mem[ptr]` and `scan_addr`←`ptr`, then go to OUT.
  - Else, `ptr`←`ptr`+1 and stay in FETCH (skip one invalid entry per cycle).
- **OUT:** `scan_valid`=1. `scan_data`/`scan_addr` are stable until `scan_ready`=1. On handshake, `ptr`←`ptr`+1 and go to FETCH. The presented word is a snapshot; host writes or deletes to that address do not alter it.
- **DONE:** `scan_done`=1 for one cycle, then go to IDLE.

Scan rules:
- `scan_start` outside IDLE is ignored.
- Host writes during a scan to addresses ≥ `ptr` are seen by the scan; writes to addresses < `ptr` are not.
- `ptr` is ADDR_WIDTH+1 bits so that DEPTH = 2^ADDR_WIDTH terminates without wrapping.

Reset (asynchronous) clears all valid bits and sets `count`=0, `dout`=0, `dout_valid`=0, `dout_hit`=0, `err`=0, `scan_valid`=0, `scan_data`=0, `scan_addr`=0, `busy`=0, `scan_done`=0, and state IDLE. Memory data is not cleared. A reset during a scan aborts it with no `scan_done`.

## Timing
- Host read latency: 1 cycle (data on the edge after the request).
- A write followed by a read of the same address in the next cycle returns the new data.
- A read in the same cycle as a write is impossible (single port).
- `count` updates on the edge that performs the write or delete.
- Scan throughput:
  - valid entry: 2 cycles minimum (FETCH + OUT with `scan_ready`=1);
  - invalid entry: 1 cycle;
  - each host-op cycle during FETCH adds 1 stall cycle.
- `scan_start` to first `scan_valid`: ≥ 2 cycles.
- Last handshake to `scan_done`: 2 cycles (FETCH sees `ptr`==DEPTH, then DONE).
- Empty DB: `scan_done` arrives DEPTH+2 cycles after `scan_start`.

## Test plan
- **Load and read back:** write 0xE0, 0x90, 0x48, 0x18 to addresses 0–3, then read 0–3. Expect `dout` equal to the written values with `dout_hit`=1 and `dout_valid` one cycle after each request. Read address 4: `dout_hit`=0. `count`=4.
- **Overwrite and delete:** rewrite address 1 with 0x91: `count` stays 4. Delete address 2: `count`=3. Delete address 2 again: `count`=3. Read address 2: `dout`=0x48, `dout_hit`=0.
- **Out of range:** with DEPTH=200, write to address 210. Expect `err` pulse, `count` unchanged, no `dout_valid`.
- **Scan with backpressure:** with entries 0, 1, 3 valid, pulse `scan_start` and hold `scan_ready`=0 for 5 cycles at the first beat. Expect `scan_valid` held with addr 0 / 0xE0 stable. Beats follow in order 0, 1, 3, then one `scan_done` pulse and `busy`=0.
- **Scan vs host contention:** during a scan, issue host reads every cycle for 3 cycles while the FSM is in FETCH. Expect the scan to stall 3 cycles, lose no entries, and return correct host reads. A `scan_start` while `busy` is ignored.
- **Reset mid-scan:** assert `reset` while in OUT. Expect immediate `scan_valid`=0, `busy`=0, `count`=0, and no `scan_done`. A subsequent read of address 0 returns `dout_hit`=0.

Source files
------------

// File: rtl/clausedb_scan.sv
`default_nettype none
// ============================================================================
//  Module      : clausedb_scan
//  Description : Clause-database RAM with per-entry valid bits, entry count,
//                registered host reads and an autonomous scan engine that
//                streams every valid clause over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module clausedb_scan #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  r_w,
    input  logic                  del,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  dout_hit,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  scan_start,
    input  logic                  scan_ready,
    output logic                  scan_valid,
    output logic [DATA_WIDTH-1:0] scan_data,
    output logic [ADDR_WIDTH-1:0] scan_addr,
    output logic                  busy,
    output logic                  scan_done
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_W   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_OUT   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      valid;

    state_t                state, state_next;
    logic [ADDR_WIDTH:0]   ptr, ptr_next;
    logic                  scan_load;
    logic [ADDR_WIDTH-1:0] ptr_idx;

    logic in_range;
    logic host_wr;
    logic host_del;
    logic host_rd;

    assign in_range = ({1'b0, address} < DEPTH_W);
    assign host_wr  = en & in_range & ~del & ~r_w;
    assign host_del = en & in_range & del;
    assign host_rd  = en & in_range & ~del & r_w;
    // ptr only indexes storage in FETCH when ptr < DEPTH, so the top bit is
    // not needed for addressing.
    assign ptr_idx  = ptr[ADDR_WIDTH-1:0];

    // Clause storage: data is never reset, only the valid bits are.
    always_ff @(posedge clock) begin
        if (host_wr) begin
            mem[address] <= din;
        end
    end

    // Valid bits and population count; overwrites and repeat deletes leave count alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= '0;
            count <= '0;
        end else if (host_wr) begin
            valid[address] <= 1'b1;
            if (!valid[address]) begin
                count <= count + ONE_W;
            end
        end else if (host_del) begin
            valid[address] <= 1'b0;
            if (valid[address]) begin
                count <= count - ONE_W;
            end
        end
    end

    // Registered host read port plus one-cycle error pulse for bad addresses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_hit   <= 1'b0;
            err        <= 1'b0;
        end else begin
            dout_valid <= host_rd;
            err        <= en & ~in_range;
            dout_hit   <= 1'b0;
            if (host_rd) begin
                dout     <= mem[address];
                dout_hit <= valid[address];
            end
        end
    end

    // Scan engine state, pointer and the snapshot of the presented clause.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            scan_data <= '0;
            scan_addr <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            if (scan_load) begin
                scan_data <= mem[ptr_idx];
                scan_addr <= ptr_idx;
            end
        end
    end

    // Scan next-state: host traffic owns the single port, so FETCH yields to it.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        scan_load  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (scan_start) begin
                    ptr_next   = '0;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (ptr == DEPTH_W) begin
                    state_next = S_DONE;
                end else if (en) begin
                    state_next = S_FETCH;
                end else if (valid[ptr_idx]) begin
                    scan_load  = 1'b1;
                    state_next = S_OUT;
                end else begin
                    ptr_next = ptr + ONE_W;
                end
            end
            S_OUT: begin
                if (scan_ready) begin
                    ptr_next   = ptr + ONE_W;
                    state_next = S_FETCH;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign scan_valid = (state == S_OUT);
    assign busy       = (state != S_IDLE);
    assign scan_done  = (state == S_DONE);

endmodule
`default_nettype wire
